usb_crc_appender: RTL and testbench

- Parametrised bit-serial CRC stage for the USB transmit path. It sits between the bit-stream encoder (upstream) and the bit stuffer (downstream).
- Passes PID bits through unmodified. Accumulates CRC over the packet body and appends the complemented remainder MSB-first, selected per packet by mode.
- Replaces the fixed-delay FIFO approach with zero-latency valid/ready streaming. Adds parametrised CRC widths and polynomials, zero-length-packet support and a framing error flag.

---
 rtl/usb_crc_appender.sv | 200 ++++++++++++++++++++
 tb/tb_usb_crc_appender.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc_appender.sv
// Bit-serial CRC stage on the USB transmit path, between the bit-stream
// encoder and the bit stuffer. PID bits pass through untouched. The body
// feeds a token (A) or data (B) CRC, and the complemented remainder is
// appended MSB-first. Handshake packets pass through with no CRC.
// Pass-through is zero-latency valid/ready.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, mode            packet start request and type (01 token, 11 data, 10 handshake)
//   in_valid/in_bit/in_last/in_ready       upstream bit stream
//   out_valid/out_bit/out_first/out_last/out_ready  downstream bit stream
//   busy                   packet in progress
//   err                    one-cycle pulse after a framing error in the PID
module usb_crc_appender #(
    parameter int unsigned          CRC_A_W    = 5,
    parameter logic [CRC_A_W-1:0]   CRC_A_POLY = 5'h05,
    parameter int unsigned          CRC_B_W    = 16,
    parameter logic [CRC_B_W-1:0]   CRC_B_POLY = 16'h8005,
    parameter int unsigned          PID_BITS   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_first,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CRC_W = (CRC_A_W > CRC_B_W) ? CRC_A_W : CRC_B_W;
    localparam int unsigned IDX_W = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam int unsigned CNT_W = $clog2(PID_BITS + 1);

    localparam logic [1:0] MODE_TOKEN = 2'b01;
    localparam logic [1:0] MODE_DATA  = 2'b11;
    localparam logic [1:0] MODE_HS    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PID,
        S_BODY,
        S_CRC
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   crc_idx_q, crc_idx_d;
    logic               err_q, err_d;

    logic [CRC_A_W-1:0] crc_a;
    logic [CRC_B_W-1:0] crc_b;
    logic               fb_a, fb_b;
    logic [CRC_W-1:0]   crc_upd;
    logic [IDX_W-1:0]   crc_top_idx;
    logic               xfer;
    logic               pid_last;
    logic               pid_end_hs;
    logic               pid_end_zlp;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'b00;
            crc_q     <= '1;
            bit_cnt_q <= '0;
            crc_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_d;
            crc_idx_q <= crc_idx_d;
            err_q     <= err_d;
        end
    end

    // One LFSR step for the active CRC; token mode touches only the low CRC_A_W bits
    always_comb begin
        crc_a   = crc_q[CRC_A_W-1:0];
        crc_b   = crc_q[CRC_B_W-1:0];
        fb_a    = in_bit ^ crc_a[CRC_A_W-1];
        fb_b    = in_bit ^ crc_b[CRC_B_W-1];
        crc_upd = crc_q;
        if (mode_q == MODE_TOKEN) begin
            crc_upd[CRC_A_W-1:0] = {crc_a[CRC_A_W-2:0], 1'b0} ^ (CRC_A_POLY & {CRC_A_W{fb_a}});
        end else begin
            crc_upd[CRC_B_W-1:0] = {crc_b[CRC_B_W-2:0], 1'b0} ^ (CRC_B_POLY & {CRC_B_W{fb_b}});
        end
        crc_top_idx = (mode_q == MODE_TOKEN) ? IDX_W'(CRC_A_W - 1) : IDX_W'(CRC_B_W - 1);
    end

    // Next-state and streaming outputs
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        crc_d     = crc_q;
        bit_cnt_d = bit_cnt_q;
        crc_idx_d = crc_idx_q;
        err_d     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;

        xfer        = in_valid & out_ready;
        pid_last    = (bit_cnt_q == CNT_W'(PID_BITS - 1));
        pid_end_hs  = pid_last && (mode_q == MODE_HS);
        pid_end_zlp = pid_last && (mode_q == MODE_DATA);

        case (state_q)
            S_IDLE: begin
                if (start && (mode != 2'b00)) begin
                    state_d   = S_PID;
                    mode_d    = mode;
                    crc_d     = '1;
                    bit_cnt_d = '0;
                end
            end

            S_PID: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_bit   = in_bit;
                out_first = (bit_cnt_q == '0);
                // A zero-length data packet still owes its CRC, so it is not last here
                out_last  = in_last && !pid_end_zlp;
                if (xfer) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (in_last) begin
                        if (pid_end_hs) begin
                            state_d = S_IDLE;
                        end else if (pid_end_zlp) begin
                            state_d   = S_CRC;
                            crc_idx_d = IDX_W'(CRC_B_W - 1);
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (pid_last) begin
                        state_d = S_BODY;
                    end
                end
            end

            S_BODY: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_bit   = in_bit;
                out_last  = in_last && (mode_q == MODE_HS);
                if (xfer) begin
                    if (mode_q != MODE_HS) begin
                        crc_d = crc_upd;
                    end
                    if (in_last) begin
                        if (mode_q == MODE_HS) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_CRC;
                            crc_idx_d = crc_top_idx;
                        end
                    end
                end
            end

            S_CRC: begin
                out_valid = 1'b1;
                out_bit   = ~crc_q[crc_idx_q];
                out_last  = (crc_idx_q == '0);
                if (out_ready) begin
                    if (crc_idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        crc_idx_d = crc_idx_q - IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_usb_crc_appender.sv
module tb_usb_crc_appender;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_bit;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_first;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       err;

    int   total;
    int   bad;
    int   err_cnt;
    bit   bp_en;
    bit   crc_phase;

    exp_t exp_q[$];
    bit   got_q[$];
    bit   tx_q[$];

    usb_crc_appender dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_first (out_first),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per accepted output bit
    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (err) err_cnt++;
                if (out_valid && out_ready) begin
                    got_q.push_back(out_bit);
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: bit=%0b first=%0b last=%0b required=none",
                                 out_bit, out_first, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_bit, out_first, out_last} !== {e.b, e.first, e.last}) begin
                            bad++;
                            $display("FAIL out_bit#%0d: bit/first/last=%0b%0b%0b required=%0b%0b%0b",
                                     got_q.size() - 1, out_bit, out_first, out_last,
                                     e.b, e.first, e.last);
                        end
                    end
                end
            end
        end
    endtask

    // Downstream ready: always 1 unless backpressure is enabled; once in CRC, hold low 3 cycles
    task automatic run_bp();
        bit held;
        int hold_cnt;
        held = 0;
        hold_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_en) begin
                out_ready = 1'b1;
                held = 0;
                hold_cnt = 0;
            end else begin
                if (crc_phase && !held) begin
                    held = 1;
                    hold_cnt = 3;
                end
                if (hold_cnt > 0) begin
                    out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    function automatic logic [15:0] lfsr_run(input int w, input logic [15:0] poly,
                                             input int lo, input int hi, input bit from_got);
        logic [15:0] mask;
        logic [15:0] c;
        logic        b;
        logic        fb;
        mask = 16'hFFFF >> (16 - w);
        c = mask;
        for (int i = lo; i <= hi; i++) begin
            b  = from_got ? got_q[i] : tx_q[i];
            fb = b ^ c[w-1];
            c  = ((c << 1) ^ (fb ? poly : 16'h0)) & mask;
        end
        return c;
    endfunction

    task automatic prep();
        got_q.delete();
        tx_q.delete();
        err_cnt = 0;
    endtask

    task automatic add_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(v[i]);
    endtask

    task automatic push_exp(input logic b, input logic first, input logic last);
        exp_t e;
        e.b = b;
        e.first = first;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_pass(input int n, input int last_idx);
        for (int i = 0; i < n; i++) push_exp(tx_q[i], i == 0, i == last_idx);
    endtask

    task automatic do_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'b00;
    endtask

    task automatic send_bits(input int n, input int last_idx);
        int cnt;
        bit ok;
        ok = 1;
        for (int i = 0; i < n && ok; i++) begin
            in_valid = 1'b1;
            in_bit   = tx_q[i];
            in_last  = (i == last_idx);
            cnt = 0;
            @(negedge clk);
            while (!in_ready && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL send_timeout: bit=%0d in_ready=0 required=1", i);
                ok = 0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Token OUT, ADDR 0x15, ENDP 0xE: CRC5 remainder 01000, emitted complement 10111
    task automatic run_token(input bit bp);
        logic [4:0] tok_emit;
        tok_emit = 5'b10111;
        prep();
        add_bits(8'hE1, 8);
        add_bits(8'h15, 7);
        add_bits(8'h0E, 4);
        push_pass(19, -1);
        for (int i = 4; i >= 0; i--) push_exp(tok_emit[i], 1'b0, i == 0);
        bp_en = bp;
        do_start(2'b01);
        send_bits(19, -1 + 19);
        crc_phase = 1;
        wait_idle(bp ? "tok_bp" : "tok");
        crc_phase = 0;
        bp_en = 0;
        chk(bp ? "tok_bp_len" : "tok_len", 32'(got_q.size()), 32'd24);
        chk(bp ? "tok_bp_residue" : "tok_residue", 32'(lfsr_run(5, 16'h0005, 8, 23, 1)), 32'h0C);
        chk(bp ? "tok_bp_err" : "tok_err", 32'(err_cnt), 32'd0);
    endtask

    // DATA0 with bytes 00 01 02 03
    task automatic run_data(input string name);
        logic [15:0] c;
        prep();
        add_bits(8'hC3, 8);
        for (int k = 0; k < 4; k++) add_bits(8'(k), 8);
        push_pass(40, -1);
        c = lfsr_run(16, 16'h8005, 8, 39, 0);
        for (int i = 15; i >= 0; i--) push_exp(~c[i], 1'b0, i == 0);
        do_start(2'b11);
        send_bits(40, 39);
        wait_idle(name);
        chk({name, "_len"}, 32'(got_q.size()), 32'd56);
        chk({name, "_residue"}, 32'(lfsr_run(16, 16'h8005, 8, 55, 1)), 32'h800D);
        chk({name, "_err"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        err_cnt   = 0;
        bp_en     = 0;
        crc_phase = 0;
        rst_n     = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        fork
            run_monitor();
            run_bp();
            begin
                #100000;
                $display("FAIL watchdog: sim time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_first", 32'(out_first), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // IDLE: in_valid not consumed, mode 00 start ignored
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        do_start(2'b00);
        @(negedge clk);
        chk("mode00_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Handshake ACK, then a token started in the single idle cycle after it
        prep();
        add_bits(8'hD2, 8);
        push_pass(8, 7);
        do_start(2'b10);
        send_bits(8, 7);
        @(negedge clk);
        chk("hs_busy_after", 32'(busy), 32'd0);
        chk("hs_len", 32'(got_q.size()), 32'd8);
        chk("hs_err", 32'(err_cnt), 32'd0);
        run_token(0);

        run_data("data");

        // Zero-length data packet: PID then 16 zeros
        prep();
        add_bits(8'hC3, 8);
        push_pass(8, -1);
        for (int i = 15; i >= 0; i--) push_exp(1'b0, 1'b0, i == 0);
        do_start(2'b11);
        send_bits(8, 7);
        wait_idle("zlp");
        chk("zlp_len", 32'(got_q.size()), 32'd24);
        chk("zlp_err", 32'(err_cnt), 32'd0);

        run_token(1);

        // Framing error: token with in_last on PID bit 5
        prep();
        add_bits(8'hE1, 8);
        push_pass(6, 5);
        do_start(2'b01);
        send_bits(6, 5);
        @(negedge clk);
        chk("perr_err_high", 32'(err), 32'd1);
        chk("perr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("perr_err_low", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        chk("perr_err_cycles", 32'(err_cnt), 32'd1);
        chk("perr_len", 32'(got_q.size()), 32'd6);
        chk("perr_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-BODY of a data packet
        prep();
        add_bits(8'hC3, 8);
        add_bits(8'hA5, 8);
        add_bits(8'h3C, 8);
        push_pass(20, -1);
        do_start(2'b11);
        send_bits(20, -1);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #1;
        chk("mid_body_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_bit", 32'(out_bit), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_out_first", 32'(out_first), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_drained", 32'(exp_q.size()), 32'd0);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_data("data_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
